cpuc_seq_ctrl: RTL and testbench
================================

// Module: cpuc_seq_ctrl
// PURPOSE
//  Program sequencer for the CPUC datapath: owns the PC, fetches instructions from the instruction memory,
//  decodes them and issues configuration words to the component fabric (regs/adders/cmp/equal) with a
//  valid/ready handshake. Resolves jumps and conditional branches on comparator/equal results. Sits between
//  inst mem and the datapath configuration input.
// PARAMETERS
//  DATA_WIDTH    32  instruction/config word width (from cpuc_package)
//  PROGRAM_SIZE  32  number of instructions; PC_W = $clog2(PROGRAM_SIZE)
//  NUM_COND      4   condition inputs = NUM_OF_CMP + NUM_OF_EQUAL
// PORTS
//  clk         in   1           clock
//  rst_n       in   1           synchronous active-low reset
//  start       in   1           begin execution at PC 0 (sampled in IDLE/HALT only)
//  stop        in   1           abort; return to IDLE
//  imem_rd_en  out  1           instruction read strobe
//  imem_addr   out  PC_W        instruction address (= pc)
//  imem_rdata  in   DATA_WIDTH  instruction, valid the cycle after imem_rd_en
//  cond_vec    in   NUM_COND    cmp/equal result bits from datapath
//  cfg_valid   out  1           config word valid
//  cfg_ready   in   1           datapath accepts config word
//  cfg_data    out  28          config payload
//  pc          out  PC_W        current PC
//  busy        out  1           state is FETCH or EXEC
//  halted      out  1           state is HALT
//  err         out  1           sticky: illegal opcode/target; cleared by start
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; pc, cfg_data, loop_cnt=0; all 1-bit outputs 0.
//  Instr: [31:28] opcode, [27:0] payload. NOP=0, EXEC=1, JMP=2, BRC=3, LDCNT=4, DJNZ=5, HALT=F.
//  FSM IDLE -> FETCH (start) -> EXEC -> FETCH ... -> HALT. HALT -> FETCH on start (pc=0, err=0).
//  FETCH: imem_rd_en=1, imem_addr=pc; always -> EXEC next cycle. Min 2 cycles/instr.
//  EXEC decode of imem_rdata (registered in EXEC, not re-read):
//   NOP: pc+1. EXEC: cfg_valid=1, cfg_data=payload; hold both stable until cfg_ready; pc+1 in handshake cycle.
//   JMP: pc=payload[PC_W-1:0]. BRC: sel=payload[27:24]; taken if sel<NUM_COND && cond_vec[sel], target as JMP,
//   else pc+1; sel>=NUM_COND is not-taken, no error. HALT: -> HALT, pc unchanged.
//  pc+1 at PROGRAM_SIZE-1 wraps to 0 (no error). Target >= PROGRAM_SIZE (non-pow2 size): -> HALT, err=1.
//  Undefined opcode (incl. 4/5 without macro): -> HALT, err=1, no cfg_valid.
//  stop: -> IDLE next cycle from any state, drops cfg_valid even mid-handshake; pc holds. stop beats start.
//  cfg_valid never depends combinationally on cfg_ready; cfg_ready ignored when cfg_valid=0.
// CONFIGURATION
//  CPUC_SEQ_LOOP_EN defined: 16-bit loop_cnt. LDCNT: loop_cnt=payload[15:0], pc+1.
//   DJNZ: loop_cnt-1; if result !=0 jump to payload[PC_W-1:0] else pc+1; DJNZ at loop_cnt=0 -> not taken,
//   counter stays 0 (no wrap to FFFF). loop_cnt reset only by rst_n.
//  Not defined: no counter logic; opcodes 4/5 illegal (HALT, err=1).
// STRUCTURE
//  cpuc_package gains: t_cpuc_seq_opcode enum (4b), t_cpuc_seq_state enum, PC_WIDTH=$clog2(PROGRAM_SIZE),
//  NUM_OF_COND=NUM_OF_CMP+NUM_OF_EQUAL, t_cpuc_instr packed struct {opcode, payload}.
//  Sub-module cpuc_seq_decode: combinational opcode/target/legality decode; FSM, PC, counter stay in top.
// TESTING
//  1 start; mem={EXEC 0x123, HALT}, cfg_ready=1 -> cfg_data=0x123 one cycle, halted=1 at pc=1, err=0.
//  2 EXEC with cfg_ready low 5 cycles -> cfg_valid/cfg_data stable 5 cycles, pc advances only on ready.
//  3 BRC sel=2 tgt=7: cond_vec=0100 -> pc=7; cond_vec=0000 -> pc+1; sel=9 -> pc+1, err=0.
//  4 JMP 31 then NOP -> pc wraps 31->0; opcode 0xA -> HALT, err=1; start clears err, pc=0.
//  5 stop during EXEC wait -> IDLE next cycle, cfg_valid=0; rst_n low mid-run -> all outputs reset values.
//  6 LOOP_EN: LDCNT 3, body EXEC, DJNZ body -> exactly 3 cfg handshakes; without macro LDCNT -> err=1.

Source files
------------

// File: rtl/cpuc_seq_ctrl_pkg.sv
// cpuc_seq_ctrl_pkg: shared types and constants for the CPUC program sequencer.
// Contents: datapath sizes, opcode and FSM state enums, instruction struct and a PC increment helper.
// Config: CPUC_SEQ_LOOP_EN (used by the sequencer files) enables the LDCNT/DJNZ loop counter.
package cpuc_seq_ctrl_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int PAYLOAD_WIDTH  = DATA_WIDTH - 4;
  localparam int PROGRAM_SIZE   = 32;
  localparam int PC_WIDTH       = $clog2(PROGRAM_SIZE);
  localparam int NUM_OF_CMP     = 2;
  localparam int NUM_OF_EQUAL   = 2;
  localparam int NUM_OF_COND    = NUM_OF_CMP + NUM_OF_EQUAL;
  localparam int LOOP_CNT_WIDTH = 16;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_EXEC  = 4'h1,
    OP_JMP   = 4'h2,
    OP_BRC   = 4'h3,
    OP_LDCNT = 4'h4,
    OP_DJNZ  = 4'h5,
    OP_HALT  = 4'hF
  } t_cpuc_seq_opcode;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } t_cpuc_seq_state;

  typedef struct packed {
    logic [3:0]               opcode;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } t_cpuc_instr;

  // Sequential PC step; the last program slot wraps back to slot 0.
  function automatic int seq_pc_inc(input int pc, input int size);
    return (pc >= size - 1) ? 0 : pc + 1;
  endfunction

endpackage

// File: rtl/cpuc_seq_ctrl_if.sv
// cpuc_seq_ctrl_if: instruction-memory read port and datapath config handshake of the sequencer.
// Signals: imem_rd_en/imem_addr/imem_rdata (rdata valid the cycle after rd_en),
//          cfg_valid/cfg_ready/cfg_data (valid/ready config word). master = sequencer, slave = memory/fabric.
interface cpuc_seq_ctrl_if
  import cpuc_seq_ctrl_pkg::*;
#(
  parameter int PC_W = PC_WIDTH
) ();

  logic                     imem_rd_en;
  logic [PC_W-1:0]          imem_addr;
  logic [DATA_WIDTH-1:0]    imem_rdata;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [PAYLOAD_WIDTH-1:0] cfg_data;

  modport master (
    output imem_rd_en, imem_addr, cfg_valid, cfg_data,
    input  imem_rdata, cfg_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, cfg_valid, cfg_data,
    output imem_rdata, cfg_ready
  );

endinterface

// File: rtl/cpuc_seq_ctrl_decode.sv
// cpuc_seq_ctrl_decode: combinational opcode legality, branch-condition and jump-target range decode.
// Ports: opcode_i/sel_i/tgt_i instruction fields, cond_vec_i condition bits;
//        op_o (OP_HALT when illegal), legal_o, tgt_ok_o, brc_taken_o. CPUC_SEQ_LOOP_EN makes LDCNT/DJNZ legal.
module cpuc_seq_ctrl_decode
  import cpuc_seq_ctrl_pkg::*;
#(
  parameter int PROG_SIZE = PROGRAM_SIZE,
  parameter int NUM_COND  = NUM_OF_COND,
  parameter int PC_W      = $clog2(PROG_SIZE)
) (
  input  logic [3:0]          opcode_i,
  input  logic [3:0]          sel_i,
  input  logic [PC_W-1:0]     tgt_i,
  input  logic [NUM_COND-1:0] cond_vec_i,
  output t_cpuc_seq_opcode    op_o,
  output logic                legal_o,
  output logic                tgt_ok_o,
  output logic                brc_taken_o
);

  always_comb begin
    legal_o = 1'b0;
    case (opcode_i)
      OP_NOP, OP_EXEC, OP_JMP, OP_BRC, OP_HALT: legal_o = 1'b1;
`ifdef CPUC_SEQ_LOOP_EN
      OP_LDCNT, OP_DJNZ: legal_o = 1'b1;
`endif
      default: legal_o = 1'b0;
    endcase
  end

  assign op_o = legal_o ? t_cpuc_seq_opcode'(opcode_i) : OP_HALT;

  // Only reachable for non power-of-two program sizes.
  assign tgt_ok_o = int'(tgt_i) < PROG_SIZE;

  // Selectors beyond the condition vector simply read as not-taken.
  always_comb begin
    brc_taken_o = 1'b0;
    for (int i = 0; i < NUM_COND; i++) begin
      if (int'(sel_i) == i && cond_vec_i[i]) brc_taken_o = 1'b1;
    end
  end

endmodule

// File: rtl/cpuc_seq_ctrl.sv
// cpuc_seq_ctrl: program sequencer; owns the PC, fetches/decodes instructions, issues config words.
// Ports: clk, rst_n (sync, active-low), start_i, stop_i, cond_vec_i, bus (imem + cfg handshake),
//        pc_o, busy_o, halted_o, err_o. CPUC_SEQ_LOOP_EN adds the 16-bit loop counter (LDCNT/DJNZ).
module cpuc_seq_ctrl
  import cpuc_seq_ctrl_pkg::*;
#(
  parameter int PROG_SIZE = PROGRAM_SIZE,
  parameter int NUM_COND  = NUM_OF_COND,
  parameter int PC_W      = $clog2(PROG_SIZE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [NUM_COND-1:0] cond_vec_i,
  cpuc_seq_ctrl_if.master     bus,
  output logic [PC_W-1:0]     pc_o,
  output logic                busy_o,
  output logic                halted_o,
  output logic                err_o
);

  t_cpuc_seq_state          state_q;
  logic [PC_W-1:0]          pc_q;
  logic                     rd_en_q;
  logic                     cfg_valid_q;
  logic [PAYLOAD_WIDTH-1:0] cfg_data_q;
  logic                     err_q;

  t_cpuc_instr              instr;
  t_cpuc_seq_opcode         dec_op;
  logic                     dec_legal;
  logic                     dec_tgt_ok;
  logic                     dec_brc_taken;
  logic                     take_jump;
  logic [PC_W-1:0]          pc_inc;
  logic [PC_W-1:0]          tgt;

  assign instr  = bus.imem_rdata;
  assign tgt    = instr.payload[PC_W-1:0];
  assign pc_inc = PC_W'(seq_pc_inc(int'(pc_q), PROG_SIZE));

`ifdef CPUC_SEQ_LOOP_EN
  logic [LOOP_CNT_WIDTH-1:0] loop_cnt_q;
  logic [LOOP_CNT_WIDTH-1:0] loop_cnt_d;
  // DJNZ saturates at zero instead of wrapping to all-ones.
  assign loop_cnt_d = (loop_cnt_q == '0) ? '0 : loop_cnt_q - 1'b1;
`endif

  cpuc_seq_ctrl_decode #(
    .PROG_SIZE (PROG_SIZE),
    .NUM_COND  (NUM_COND),
    .PC_W      (PC_W)
  ) u_decode (
    .opcode_i    (instr.opcode),
    .sel_i       (instr.payload[PAYLOAD_WIDTH-1 -: 4]),
    .tgt_i       (tgt),
    .cond_vec_i  (cond_vec_i),
    .op_o        (dec_op),
    .legal_o     (dec_legal),
    .tgt_ok_o    (dec_tgt_ok),
    .brc_taken_o (dec_brc_taken)
  );

  always_comb begin
    take_jump = 1'b0;
    case (dec_op)
      OP_JMP:  take_jump = 1'b1;
      OP_BRC:  take_jump = dec_brc_taken;
`ifdef CPUC_SEQ_LOOP_EN
      OP_DJNZ: take_jump = (loop_cnt_d != '0);
`endif
      default: take_jump = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      rd_en_q     <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_data_q  <= '0;
      err_q       <= 1'b0;
`ifdef CPUC_SEQ_LOOP_EN
      loop_cnt_q  <= '0;
`endif
    end else if (stop_i) begin
      // Abort wins over everything, including a pending config handshake.
      state_q     <= S_IDLE;
      rd_en_q     <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start_i) begin
            state_q <= S_FETCH;
            rd_en_q <= 1'b1;
            pc_q    <= '0;
            err_q   <= 1'b0;
          end
        end
        S_FETCH: begin
          state_q <= S_EXEC;
          rd_en_q <= 1'b0;
        end
        S_EXEC: begin
          // cfg_valid_q doubles as "waiting for cfg_ready"; imem_rdata is not looked at again.
          if (cfg_valid_q) begin
            if (bus.cfg_ready) begin
              cfg_valid_q <= 1'b0;
              pc_q        <= pc_inc;
              state_q     <= S_FETCH;
              rd_en_q     <= 1'b1;
            end
          end else if (!dec_legal || (take_jump && !dec_tgt_ok)) begin
            state_q <= S_HALT;
            err_q   <= 1'b1;
          end else if (dec_op == OP_HALT) begin
            state_q <= S_HALT;
          end else if (dec_op == OP_EXEC) begin
            cfg_valid_q <= 1'b1;
            cfg_data_q  <= instr.payload;
          end else begin
            pc_q    <= take_jump ? tgt : pc_inc;
            state_q <= S_FETCH;
            rd_en_q <= 1'b1;
`ifdef CPUC_SEQ_LOOP_EN
            if (dec_op == OP_LDCNT) loop_cnt_q <= instr.payload[LOOP_CNT_WIDTH-1:0];
            if (dec_op == OP_DJNZ)  loop_cnt_q <= loop_cnt_d;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_rd_en = rd_en_q;
  assign bus.imem_addr  = pc_q;
  assign bus.cfg_valid  = cfg_valid_q;
  assign bus.cfg_data   = cfg_data_q;

  assign pc_o     = pc_q;
  assign busy_o   = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted_o = (state_q == S_HALT);
  assign err_o    = err_q;

endmodule

// File: tb/tb_cpuc_seq_ctrl.sv
// tb_cpuc_seq_ctrl: self-checking bench for the CPUC program sequencer.
// Single-instruction vector table, hand-written multi-cycle sequences, randomized programs vs an interpreter.
// Optional loop-counter checks follow CPUC_SEQ_LOOP_EN.
module tb_cpuc_seq_ctrl;
  import cpuc_seq_ctrl_pkg::*;

  localparam int PW = PC_WIDTH;
  localparam logic [31:0] W_HALT = 32'hF000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start_i;
  logic          stop_i;
  logic [3:0]    cond_vec;
  logic [PW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          err;

  cpuc_seq_ctrl_if ifc ();

  cpuc_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .cond_vec_i (cond_vec),
    .bus        (ifc),
    .pc_o       (pc),
    .busy_o     (busy),
    .halted_o   (halted),
    .err_o      (err)
  );

  // Synchronous instruction memory: data appears the cycle after the read strobe.
  logic [31:0] mem [PROGRAM_SIZE];
  always @(posedge clk) if (ifc.imem_rd_en) ifc.imem_rdata <= mem[ifc.imem_addr];

  int total = 0;
  int bad   = 0;

  logic [27:0] got_q[$];
  logic [27:0] exp_q[$];
  bit          stab_bad;
  int          m_pc;
  bit          m_err;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  cv;
    int          exp_pc;
    bit          exp_err;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] instr, input logic [3:0] cv, input int epc, input bit eerr);
    vec_t v;
    v.instr = instr; v.cv = cv; v.exp_pc = epc; v.exp_err = eerr;
    vt.push_back(v);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < PROGRAM_SIZE; i++) mem[i] = W_HALT;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!ifc.cfg_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, ifc.cfg_valid, 1);
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", halted, 1);
  endtask

  // Start the program, drive cfg_ready (random or always-high), collect handshaked
  // payloads and flag any change of a pending word before it is accepted.
  task automatic run_prog(input bit rnd_ready, input int budget);
    bit          prev_wait = 1'b0;
    logic [27:0] prev_data = '0;
    bit          rdy;
    int          n = 0;
    got_q.delete();
    stab_bad = 1'b0;
    pulse_start();
    while (!halted && n < budget) begin
      if (prev_wait && !(ifc.cfg_valid && ifc.cfg_data == prev_data)) stab_bad = 1'b1;
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.cfg_ready = rdy;
      if (ifc.cfg_valid && rdy) got_q.push_back(ifc.cfg_data);
      prev_wait = ifc.cfg_valid && !rdy;
      prev_data = ifc.cfg_data;
      @(negedge clk);
      n++;
    end
    ifc.cfg_ready = 1'b0;
    chk("halt_reached", halted, 1);
  endtask

  // Instruction-level interpreter: walks the program, collecting EXEC payloads.
  function automatic void ref_model(input logic [3:0] cv);
    int          p;
    int          sel;
    int          tgt;
    logic [3:0]  op;
    logic [27:0] pl;
    p = 0;
    m_err = 1'b0;
    exp_q.delete();
    for (int step = 0; step < 200; step++) begin
      op  = mem[p][31:28];
      pl  = mem[p][27:0];
      tgt = int'(pl % PROGRAM_SIZE);
      sel = int'(pl[27:24]);
      if (op == 4'h0) p = (p + 1) % PROGRAM_SIZE;
      else if (op == 4'h1) begin
        exp_q.push_back(pl);
        p = (p + 1) % PROGRAM_SIZE;
      end
      else if (op == 4'h2) p = tgt;
      else if (op == 4'h3) p = (sel < 4 && cv[sel]) ? tgt : (p + 1) % PROGRAM_SIZE;
      else if (op == 4'hF) break;
      else begin
        m_err = 1'b1;
        break;
      end
    end
    m_pc = p;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit same;
    int nvalid;
    logic [27:0] seen;

    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; cond_vec = '0;
    ifc.cfg_ready = 1'b0;
    clear_mem();

    add_vec(32'h0000_0000, 4'b0000, 1, 0);   // NOP
    add_vec(32'h1000_0ABC, 4'b0000, 1, 0);   // EXEC
    add_vec(32'h2000_0007, 4'b0000, 7, 0);   // JMP 7
    add_vec(32'h2FFF_FF07, 4'b0000, 7, 0);   // JMP, upper payload bits ignored
    add_vec(32'h3200_0007, 4'b0100, 7, 0);   // BRC sel2 taken
    add_vec(32'h3200_0007, 4'b0000, 1, 0);   // BRC sel2 not taken
    add_vec(32'h3200_0007, 4'b1011, 1, 0);   // BRC sel2, other bits set
    add_vec(32'h3900_0007, 4'b1111, 1, 0);   // BRC sel9 out of range
    add_vec(32'h3300_0009, 4'b1000, 9, 0);   // BRC sel3 taken
    add_vec(32'hA000_0000, 4'b0000, 0, 1);   // illegal opcode
    add_vec(32'hE000_0003, 4'b1111, 0, 1);   // illegal opcode
    add_vec(W_HALT,        4'b0000, 0, 0);   // HALT
`ifdef CPUC_SEQ_LOOP_EN
    add_vec(32'h4000_0000, 4'b0000, 1, 0);   // LDCNT 0
    add_vec(32'h5000_0007, 4'b0000, 1, 0);   // DJNZ at zero: not taken
`else
    add_vec(32'h4000_0003, 4'b0000, 0, 1);   // LDCNT illegal
    add_vec(32'h5000_0007, 4'b0000, 0, 1);   // DJNZ illegal
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {pc, busy, halted, err, ifc.cfg_valid, ifc.imem_rd_en, ifc.imem_addr}, '0);
    chk("rst_cfg_data", ifc.cfg_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // EXEC 0x123 then HALT with ready high: one config word
    clear_mem();
    mem[0] = 32'h1000_0123;
    ifc.cfg_ready = 1'b1;
    pulse_start();
    nvalid = 0; seen = '0;
    for (int i = 0; i < 12; i++) begin
      if (ifc.cfg_valid) begin
        nvalid++;
        seen = ifc.cfg_data;
      end
      @(negedge clk);
    end
    chk("t1_valid_cycles", nvalid, 1);
    chk("t1_cfg_data", seen, 28'h123);
    chk("t1_halted_pc", {halted, err, pc}, {1'b1, 1'b0, 5'd1});
    ifc.cfg_ready = 1'b0;

    // EXEC held by cfg_ready low for 5 cycles
    clear_mem();
    mem[0] = 32'h1000_0055;
    pulse_start();
    wait_valid("t2_valid_seen", 10);
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold", {ifc.cfg_valid && ifc.cfg_data == 28'h55, pc}, {1'b1, 5'd0});
      @(negedge clk);
    end
    ifc.cfg_ready = 1'b1;
    @(negedge clk);
    ifc.cfg_ready = 1'b0;
    chk("t2_release", {ifc.cfg_valid, pc}, {1'b0, 5'd1});
    wait_halt(20);
    chk("t2_final_pc", pc, 1);

    // PC wrap 31 -> 0
    clear_mem();
    mem[0]  = 32'h2000_001F;
    mem[31] = 32'h0000_0000;
    pulse_start();
    for (int n = 0; n < 20 && pc != 5'd31; n++) @(negedge clk);
    chk("t4_pc31", pc, 31);
    for (int n = 0; n < 10 && pc != 5'd0; n++) @(negedge clk);
    chk("t4_wrap", {pc, busy}, {5'd0, 1'b1});
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("t4_stop_idle", {busy, halted}, 2'b00);

    // Illegal opcode, then start clears err
    clear_mem();
    mem[0] = 32'hA000_0000;
    pulse_start();
    wait_halt(20);
    chk("t4_illegal", {err, pc, ifc.cfg_valid}, {1'b1, 5'd0, 1'b0});
    mem[0] = 32'h0000_0000;
    pulse_start();
    chk("t4_start_clears", {err, pc, busy}, {1'b0, 5'd0, 1'b1});
    wait_halt(20);
    chk("t4_after_restart", {err, pc}, {1'b0, 5'd1});

    // stop during a pending handshake
    clear_mem();
    mem[0] = 32'h1000_0077;
    pulse_start();
    wait_valid("t5_valid_seen", 10);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("t5_stop", {ifc.cfg_valid, busy, halted, pc}, '0);
    start_i = 1'b1; stop_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0;
    @(negedge clk);
    chk("t5_stop_beats_start", busy, 0);

    // reset mid-run
    clear_mem();
    mem[0] = 32'h2000_0005;
    mem[5] = 32'h1000_0099;
    pulse_start();
    wait_valid("t5_valid_run", 20);
    chk("t5_pc_run", pc, 5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_ctrl", {pc, busy, halted, err, ifc.cfg_valid, ifc.imem_rd_en, ifc.imem_addr}, '0);
    chk("t5_rst_cfg_data", ifc.cfg_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-instruction vector table
    for (int i = 0; i < vt.size(); i++) begin
      clear_mem();
      mem[0] = vt[i].instr;
      cond_vec = vt[i].cv;
      run_prog(1'b0, 40);
      chk($sformatf("vec%0d_pc", i), pc, vt[i].exp_pc);
      chk($sformatf("vec%0d_err", i), err, vt[i].exp_err);
    end

`ifdef CPUC_SEQ_LOOP_EN
    // LDCNT 3, body EXEC, DJNZ body, then DJNZ with counter at zero
    clear_mem();
    mem[0] = 32'h4FFF_0003;
    mem[1] = 32'h1000_00AB;
    mem[2] = 32'h5000_0001;
    mem[3] = 32'h5000_0001;
    run_prog(1'b1, 300);
    chk("t6_handshakes", got_q.size(), 3);
    same = 1'b1;
    foreach (got_q[i]) if (got_q[i] !== 28'hAB) same = 1'b0;
    chk("t6_payloads", same, 1);
    chk("t6_final", {err, pc}, {1'b0, 5'd4});
`endif

    // Randomized programs with forward-only control flow
    for (int t = 0; t < 25; t++) begin
      int r;
      int tg;
      for (int p = 0; p < PROGRAM_SIZE - 1; p++) begin
        r  = $urandom_range(0, 19);
        tg = $urandom_range(p + 1, PROGRAM_SIZE - 1);
        if (r < 4)       mem[p] = {4'h0, 28'($urandom)};
        else if (r < 9)  mem[p] = {4'h1, 28'($urandom)};
        else if (r < 12) mem[p] = {4'h2, (28'($urandom) & 28'hFFF_FFE0) | 28'(tg)};
        else if (r < 18) mem[p] = {4'h3, 4'($urandom_range(0, 5)), 19'($urandom), 5'(tg)};
        else if (r < 19) mem[p] = W_HALT;
        else             mem[p] = {4'($urandom_range(6, 14)), 28'($urandom)};
      end
      mem[PROGRAM_SIZE-1] = W_HALT;
      cond_vec = 4'($urandom);
      ref_model(cond_vec);
      run_prog(1'b1, 600);
      chk("rnd_cfg_count", got_q.size(), exp_q.size());
      same = (got_q.size() == exp_q.size());
      if (same) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) same = 1'b0;
      chk("rnd_cfg_seq", same, 1);
      chk("rnd_pc", pc, m_pc);
      chk("rnd_err", err, m_err);
      chk("rnd_cfg_stable", stab_bad, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
